alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Sequencer placed between the board inputs and the shared ALU plus binary-to-BCD converter. On a `go` request it captures the operands and function, runs the ALU for a fixed latency, and hands the result to the converter over a start/done handshake. It then publishes the final result and error flag to the display path. One operation is in flight at a time, and requests are not queued.

Parameters:
- width, 6, operand width; results are 2*width bits.
- ALU_LAT, 2, ALU result latency in clk cycles, ≥1.
- CONV_TIMEOUT, 64, maximum cycles to wait for conv_done before aborting, ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  request pulse; sampled only in IDLE.
- a  input  width  operand A.
- b  input  width  operand B.
- func  input  3  func[2]=1 selects passthrough {a,b}; func[1:0] is the ALU op.
- alu_a  output  width  captured operand A, held stable during EXEC.
- alu_b  output  width  captured operand B, held stable during EXEC.
- alu_func  output  2  captured func[1:0].
- alu_result  input  2*width  ALU result.
- alu_ovf  input  1  ALU overflow.
- conv_start  output  1  one-cycle converter start pulse.
- conv_bin  output  2*width  value to convert, held for all of CONV.
- conv_done  input  1  converter completion.
- out  output  2*width  last published result.
- err  output  1  error of last published result.
- valid  output  1  one-cycle pulse when out/err update.
- busy  output  1  high outside IDLE.

Behaviour:
- Reset: state=IDLE. out, err, valid, busy, conv_start, conv_bin, alu_a, alu_b, alu_func all 0. Counters cleared.
- Reset mid-operation: IDLE on the next edge. conv_start is never left asserted. A pending conv_done is ignored.
- Outputs are registered. States: IDLE, EXEC, CONV, DONE.
- IDLE:
  - go=1 captures a, b, func.
  - func[2]=0 → EXEC; cycle counter cnt=0.
  - func[2]=1 → CONV; conv_bin={a,b}; pending error=0.
  - go=0 → stay. busy=0.
- EXEC: lasts exactly ALU_LAT cycles. On the cycle with cnt==ALU_LAT-1, alu_result is sampled into conv_bin and alu_ovf into pending error; then → CONV.
- CONV:
  - conv_start=1 only in the first CONV cycle; conv_done is ignored in that cycle.
  - From the second cycle, conv_done=1 → DONE.
  - Timeout counter runs from CONV entry; reaching CONV_TIMEOUT without done → DONE with pending error forced to 1 and conv_bin forced to 0.
- DONE, one cycle: out<=conv_bin, err<=pending error, valid=1 during the following cycle (IDLE). Then → IDLE.
- Latency:
  - ALU op: go sampled at edge 0 → conv_start high in cycle ALU_LAT+1.
  - Passthrough: conv_start high in cycle 1.
  - valid is high one cycle after DONE.
- Error behaviour:
  - go while busy: ignored, no side effects.
  - go coincident with rst: rst wins.
  - out/err hold between operations; a new op changes them only at its valid pulse.
  - conv_done outside CONV: ignored.
- Widths: conv_bin/out are 2*width bits; alu_result is taken unmodified with no truncation.

Decomposition:
- Package alu_seq_pkg:
  - state enum (IDLE, EXEC, CONV, DONE).
  - func field constants (FUNC_PASS_BIT=2; ALU op codes 0–3).
- Sub-module seq_cnt: loadable up-counter with terminal-count compare. Instantiated once for the EXEC count and once for the CONV timeout.

Test Plan:
1. Apply rst for 2 cycles with go=1 → all outputs 0, busy=0, no conv_start.
2. ALU_LAT=2, func=0, a=5, b=7, model ALU returns 12 after 2 cycles, conv_done 5 cycles after start → conv_start in cycle 3; valid pulse with out=12, err=0; busy low afterward.
3. func=3'b100, a=3, b=2 → no EXEC; conv_start in cycle 1; out=194 ({3,2}), err=0.
4. Model asserts alu_ovf=1 with result 0 → out=0, err=1. Next op with ovf=0 clears err at its valid pulse.
5. go pulsed every cycle during an op → exactly one valid per completed op; captured operands unchanged mid-op.
6. conv_done never asserted, CONV_TIMEOUT=64 → DONE after 64 CONV cycles, out=0, err=1.
7. rst asserted in the third CONV cycle → IDLE next cycle; later conv_done ignored; the next go runs normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU sequencer.
//   state_t        - sequencer states (IDLE, EXEC, CONV, DONE)
//   FUNC_PASS_BIT  - func bit that selects passthrough of {a,b}
//   ALU_OP_*       - ALU operation codes carried on func[1:0]
//   cnt_width()    - counter width able to hold 0..n
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int FUNC_PASS_BIT = 2;

  localparam logic [1:0] ALU_OP_0 = 2'd0;
  localparam logic [1:0] ALU_OP_1 = 2'd1;
  localparam logic [1:0] ALU_OP_2 = 2'd2;
  localparam logic [1:0] ALU_OP_3 = 2'd3;

  // Bits needed to hold values 0..n, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_cnt.sv
// seq_cnt: up-counter that is reloaded to zero and flags a terminal count.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : load zero (takes priority over i_en)
//   i_en     : increment by one
//   o_tc     : high while the count equals TC
module seq_cnt #(
  parameter int W  = 4,
  parameter int TC = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == W'(TC));

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one ALU operation followed by a binary-to-BCD
// conversion and publishes the result.
//   clk, rst            : clock, synchronous active-high reset
//   go, a, b, func      : request and its operands (sampled only in IDLE)
//   alu_a/alu_b/alu_func: captured operands/op driven to the ALU
//   alu_result, alu_ovf : ALU response, sampled after ALU_LAT cycles
//   conv_start/conv_bin : converter start pulse and value to convert
//   conv_done           : converter completion
//   out, err, valid     : published result, its error flag, update pulse
//   busy                : high whenever the sequencer is not idle
//   dbg_state           : current state encoding for observation
// Handshake: conv_start is a single-cycle pulse in the first CONV cycle;
// conv_done is only honoured from the second CONV cycle on, and a missing
// conv_done after CONV_TIMEOUT CONV cycles ends the operation with err=1.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int width        = 6,
  parameter int ALU_LAT      = 2,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  input  logic [2:0]           func,
  output logic [width-1:0]     alu_a,
  output logic [width-1:0]     alu_b,
  output logic [1:0]           alu_func,
  input  logic [2*width-1:0]   alu_result,
  input  logic                 alu_ovf,
  output logic                 conv_start,
  output logic [2*width-1:0]   conv_bin,
  input  logic                 conv_done,
  output logic [2*width-1:0]   out,
  output logic                 err,
  output logic                 valid,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int EXEC_W = cnt_width(ALU_LAT - 1);
  localparam int CONV_W = cnt_width(CONV_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  w_capture;
  logic                  w_exec_last;
  logic                  w_conv_to;
  logic                  w_exec_tc;
  logic                  w_conv_tc;

  logic [width-1:0]      r_alu_a;
  logic [width-1:0]      r_alu_b;
  logic [1:0]            r_alu_func;
  logic                  r_conv_start;
  logic [2*width-1:0]    r_conv_bin;
  logic                  r_pend_err;
  logic [2*width-1:0]    r_out;
  logic                  r_err;
  logic                  r_valid;
  logic                  r_busy;

  // Both counters sit at zero outside their state, so they start from zero
  // on entry and their terminal counts mark the last allowed cycle.
  seq_cnt #(.W(EXEC_W), .TC(ALU_LAT - 1)) u_exec_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state != ST_EXEC),
    .i_en  (r_state == ST_EXEC),
    .o_tc  (w_exec_tc)
  );

  seq_cnt #(.W(CONV_W), .TC(CONV_TIMEOUT - 1)) u_conv_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state != ST_CONV),
    .i_en  (r_state == ST_CONV),
    .o_tc  (w_conv_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_exec_last = 1'b0;
    w_conv_to   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_capture = 1'b1;
          w_next    = func[FUNC_PASS_BIT] ? ST_CONV : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_exec_tc) begin
          w_exec_last = 1'b1;
          w_next      = ST_CONV;
        end
      end
      ST_CONV: begin
        // r_conv_start is high exactly in the first CONV cycle, where a
        // conv_done left over from elsewhere must not count.
        if (conv_done && !r_conv_start) begin
          w_next = ST_DONE;
        end else if (w_conv_tc) begin
          w_conv_to = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_func   <= '0;
      r_conv_start <= 1'b0;
      r_conv_bin   <= '0;
      r_pend_err   <= 1'b0;
      r_out        <= '0;
      r_err        <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid      <= (r_state == ST_DONE);
      r_busy       <= (w_next != ST_IDLE);
      r_conv_start <= (w_next == ST_CONV) && (r_state != ST_CONV);
      if (w_capture) begin
        r_alu_a    <= a;
        r_alu_b    <= b;
        r_alu_func <= func[1:0];
        if (func[FUNC_PASS_BIT]) begin
          r_conv_bin <= {a, b};
          r_pend_err <= 1'b0;
        end
      end
      if (w_exec_last) begin
        r_conv_bin <= alu_result;
        r_pend_err <= alu_ovf;
      end
      if (w_conv_to) begin
        r_conv_bin <= '0;
        r_pend_err <= 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_out <= r_conv_bin;
        r_err <= r_pend_err;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_func   = r_alu_func;
  assign conv_start = r_conv_start;
  assign conv_bin   = r_conv_bin;
  assign out        = r_out;
  assign err        = r_err;
  assign valid      = r_valid;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: ALU and converter are modelled by the driver,
// expected results come from a transaction-level model of the sequencer.
module tb_alu_seq_ctrl;

  localparam int W   = 6;
  localparam int LAT = 2;
  localparam int TO  = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           go;
  logic [W-1:0]   a, b;
  logic [2:0]     func;
  logic [W-1:0]   alu_a, alu_b;
  logic [1:0]     alu_func;
  logic [2*W-1:0] alu_result;
  logic           alu_ovf;
  logic           conv_start;
  logic [2*W-1:0] conv_bin;
  logic           conv_done;
  logic [2*W-1:0] out;
  logic           err, valid, busy;
  logic [1:0]     dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];
  logic           exp_err_q[$];

  alu_seq_ctrl #(.width(W), .ALU_LAT(LAT), .CONV_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .a(a), .b(b), .func(func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .alu_ovf(alu_ovf),
    .conv_start(conv_start), .conv_bin(conv_bin), .conv_done(conv_done),
    .out(out), .err(err), .valid(valid), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; go = 1'b1; a = '0; b = '0; func = '0;
    alu_result = '0; alu_ovf = 1'b0; conv_done = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected behaviour of one operation, from the sequencer's rules.
  task automatic model_op(input logic [W-1:0] a_i, b_i, input logic [2:0] f_i,
                          input logic [2*W-1:0] res_i, input logic ovf_i,
                          input int done_d, output int e_start, output int e_valid,
                          output logic [2*W-1:0] e_bin, output logic [2*W-1:0] e_out,
                          output logic e_err);
    e_start = f_i[2] ? 1 : LAT + 1;
    e_bin   = f_i[2] ? {a_i, b_i} : res_i;
    if (done_d >= 1 && done_d <= TO - 1) begin
      e_valid = e_start + done_d + 2;
      e_out   = e_bin;
      e_err   = f_i[2] ? 1'b0 : ovf_i;
    end else begin
      e_valid = e_start + TO + 1;
      e_out   = '0;
      e_err   = 1'b1;
    end
  endtask

  // Driver: issues one go, plays ALU and converter, records what happened.
  // Cycle 1 is the cycle right after the edge that samples go.
  task automatic run_op(input logic [W-1:0] a_i, b_i, input logic [2:0] f_i,
                        input logic [2*W-1:0] res_i, input logic ovf_i,
                        input int done_d, input bit spam,
                        output int start_cyc, output int valid_cyc,
                        output int n_start, output int n_valid,
                        output logic [2*W-1:0] bin_s, output logic [2*W-1:0] out_v,
                        output logic err_v, output bit stable, output bit held,
                        output logic busy_after);
    logic [2*W-1:0] out0;
    logic           err0;
    start_cyc = -1; valid_cyc = -1; n_start = 0; n_valid = 0;
    bin_s = '0; out_v = '0; err_v = 1'b0; stable = 1'b1; held = 1'b1;
    busy_after = 1'b1;
    @(negedge clk);
    out0 = out; err0 = err;
    go = 1'b1; a = a_i; b = b_i; func = f_i; conv_done = 1'b0;
    alu_result = (2*W)'($urandom); alu_ovf = 1'($urandom);
    @(posedge clk);
    for (int c = 1; c <= LAT + TO + 10; c++) begin
      @(negedge clk);
      if (conv_start) begin
        n_start++;
        if (start_cyc < 0) begin start_cyc = c; bin_s = conv_bin; end
      end
      if (valid) begin
        n_valid++;
        if (valid_cyc < 0) begin
          valid_cyc = c; out_v = out; err_v = err; busy_after = busy;
        end
      end else if (valid_cyc < 0 && (out !== out0 || err !== err0)) begin
        held = 1'b0;
      end
      if (busy && (alu_a !== a_i || alu_b !== b_i || alu_func !== f_i[1:0]))
        stable = 1'b0;
      go         = spam && busy;
      a          = W'($urandom);
      b          = W'($urandom);
      func       = 3'($urandom);
      alu_result = (c == LAT) ? res_i : (2*W)'($urandom);
      alu_ovf    = (c == LAT) ? ovf_i : 1'($urandom);
      conv_done  = (start_cyc >= 0 && done_d >= 0 && c == start_cyc + done_d);
      if (valid_cyc >= 0 && c >= valid_cyc + 2) break;
    end
    go = 1'b0; conv_done = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out, err, valid, busy, conv_start, conv_bin, alu_a, alu_b, alu_func} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: out=%0d err=%0b valid=%0b busy=%0b start=%0b bin=%0d alu_a=%0d alu_b=%0d func=%0d, all required 0",
                 out, err, valid, busy, conv_start, conv_bin, alu_a, alu_b, alu_func);
      end
    end
    rst = 1'b0; go = 1'b0;
  endtask

  // Runs one op and compares everything against the model.
  task automatic test_op(input string name, input logic [W-1:0] a_i, b_i,
                         input logic [2:0] f_i, input logic [2*W-1:0] res_i,
                         input logic ovf_i, input int done_d, input bit spam);
    int s, v, ns, nv, es, ev;
    logic [2*W-1:0] bs, ov, eb, eo;
    logic ev_err, ee, ba;
    bit st, hd;
    model_op(a_i, b_i, f_i, res_i, ovf_i, done_d, es, ev, eb, eo, ee);
    exp_q.push_back(eo);
    exp_err_q.push_back(ee);
    run_op(a_i, b_i, f_i, res_i, ovf_i, done_d, spam, s, v, ns, nv, bs, ov, ev_err, st, hd, ba);
    eo = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    checks++;
    if (s !== es || ns !== 1) begin
      failures++;
      $display("FAIL %s start: cycle=%0d count=%0d, required cycle=%0d count=1", name, s, ns, es);
    end
    checks++;
    if (bs !== eb) begin
      failures++;
      $display("FAIL %s conv_bin: got %0d required %0d", name, bs, eb);
    end
    checks++;
    if (v !== ev || nv !== 1) begin
      failures++;
      $display("FAIL %s valid: cycle=%0d count=%0d, required cycle=%0d count=1", name, v, nv, ev);
    end
    checks++;
    if (ov !== eo || ev_err !== ee) begin
      failures++;
      $display("FAIL %s result: out=%0d err=%0b, required out=%0d err=%0b", name, ov, ev_err, eo, ee);
    end
    checks++;
    if (ba !== 1'b0 || !st || !hd) begin
      failures++;
      $display("FAIL %s side: busy_at_valid=%0b operands_stable=%0b out_held=%0b, required 0/1/1",
               name, ba, st, hd);
    end
  endtask

  task automatic test_basic();
    test_op("alu_basic", 6'd5, 6'd7, 3'b000, 12'd12, 1'b0, 5, 1'b0);
    test_op("passthrough", 6'd3, 6'd2, 3'b100, 12'd0, 1'b1, 3, 1'b0);
  endtask

  task automatic test_ovf();
    test_op("ovf_set", 6'd63, 6'd63, 3'b001, 12'd0, 1'b1, 2, 1'b0);
    test_op("ovf_clear", 6'd9, 6'd4, 3'b010, 12'd1234, 1'b0, 1, 1'b0);
  endtask

  task automatic test_go_while_busy();
    test_op("busy_go_alu", 6'd17, 6'd40, 3'b011, 12'd4000, 1'b0, 4, 1'b1);
    test_op("busy_go_pass", 6'd33, 6'd1, 3'b110, 12'd7, 1'b0, 6, 1'b1);
  endtask

  task automatic test_timeout();
    test_op("timeout_none", 6'd1, 6'd2, 3'b000, 12'd99, 1'b0, -1, 1'b0);
    test_op("done_first_cycle", 6'd8, 6'd8, 3'b101, 12'd0, 1'b0, 0, 1'b0);
    test_op("done_last_cycle", 6'd2, 6'd9, 3'b001, 12'd321, 1'b1, TO - 1, 1'b0);
  endtask

  task automatic test_reset_mid_conv();
    int nv;
    @(negedge clk);
    go = 1'b1; a = 6'd12; b = 6'd34; func = 3'b100;
    @(posedge clk);
    @(negedge clk); go = 1'b0;   // CONV cycle 1
    @(negedge clk);              // CONV cycle 2
    @(negedge clk); rst = 1'b1;  // CONV cycle 3
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || conv_start !== 1'b0 || valid !== 1'b0 || out !== '0) begin
      failures++;
      $display("FAIL rst_mid_conv: busy=%0b start=%0b valid=%0b out=%0d, required 0/0/0/0",
               busy, conv_start, valid, out);
    end
    rst = 1'b0; conv_done = 1'b1;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid || busy || conv_start) nv++;
    end
    conv_done = 1'b0;
    checks++;
    if (nv !== 0) begin
      failures++;
      $display("FAIL stray_done: activity cycles=%0d, required 0", nv);
    end
    test_op("after_rst", 6'd21, 6'd42, 3'b000, 12'd2047, 1'b0, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int d;
      d = (n % 8 == 7) ? int'($urandom_range(0, 1)) * TO : int'($urandom_range(1, 12));
      test_op("random", W'($urandom), W'($urandom), 3'($urandom),
              (2*W)'($urandom), 1'($urandom), d, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_go_while_busy();
    test_timeout();
    test_reset_mid_conv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
